dispatch_stage: RTL and testbench

DISPATCH_STAGE -- requirements
Module: dispatch_stage

---
 rtl/dispatch_stage.sv | 180 ++++++++++++++++++
 tb/tb_dispatch_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_stage.sv
// dispatch_stage
//   Holds one group of renamed ops in a pipeline register and writes them to
//   the issue queue. It tracks operand readiness with a physical-register
//   scoreboard. Wakeup broadcasts in the same cycle are bypassed, and an older
//   producer in the same group blocks a younger consumer of its destination.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   stall              hold the pipeline register, suppress issue-queue writes
//   clear              invalidate this cycle's ops (held and incoming)
//   flush              mark every physical register ready
//   in_*               per-slot renamed ops from rename (valid, payload, regs, flags)
//   wakeup_valid/_reg  producer result broadcasts
//   iq_write           per-slot issue-queue write enable
//   iq_op              registered payload
//   iq_ready_a/_b      initial operand readiness for the issue queue
//   empty              no valid op held in the register
//   dispatched_count   running total of issue-queue writes (wraps at 2^32)
module dispatch_stage #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int PREG_NUM       = 128,
  parameter int PREG_W         = 7,
  parameter int OP_W           = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             clear,
  input  logic                             flush,
  input  logic [DISPATCH_WIDTH-1:0]        in_valid,
  input  logic [DISPATCH_WIDTH*OP_W-1:0]   in_op,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0] in_src_a,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0] in_src_b,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0] in_dst,
  input  logic [DISPATCH_WIDTH-1:0]        in_read_a,
  input  logic [DISPATCH_WIDTH-1:0]        in_read_b,
  input  logic [DISPATCH_WIDTH-1:0]        in_write,
  input  logic [DISPATCH_WIDTH-1:0]        wakeup_valid,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0] wakeup_reg,
  output logic [DISPATCH_WIDTH-1:0]        iq_write,
  output logic [DISPATCH_WIDTH*OP_W-1:0]   iq_op,
  output logic [DISPATCH_WIDTH-1:0]        iq_ready_a,
  output logic [DISPATCH_WIDTH-1:0]        iq_ready_b,
  output logic                             empty,
  output logic [31:0]                      dispatched_count
);

  // Pipeline register
  logic [DISPATCH_WIDTH-1:0]        valid_reg;
  logic [DISPATCH_WIDTH*OP_W-1:0]   op_reg;
  logic [DISPATCH_WIDTH*PREG_W-1:0] src_a_reg;
  logic [DISPATCH_WIDTH*PREG_W-1:0] src_b_reg;
  logic [DISPATCH_WIDTH*PREG_W-1:0] dst_reg;
  logic [DISPATCH_WIDTH-1:0]        read_a_reg;
  logic [DISPATCH_WIDTH-1:0]        read_b_reg;
  logic [DISPATCH_WIDTH-1:0]        write_reg;

  // Scoreboard and counter
  logic [PREG_NUM-1:0] ready_reg;
  logic [PREG_NUM-1:0] ready_next;
  logic [31:0]         count_reg;
  logic [31:0]         count_next;
  logic [31:0]         pop;

  // Incoming valids are dropped under clear so a cleared op neither reaches
  // the issue queue later nor leaves a stale scoreboard clear behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (!stall) begin
      valid_reg <= in_valid & ~{DISPATCH_WIDTH{clear}};
    end
  end

  // Payload and operand fields need no reset; valid_reg qualifies them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      op_reg     <= in_op;
      src_a_reg  <= in_src_a;
      src_b_reg  <= in_src_b;
      dst_reg    <= in_dst;
      read_a_reg <= in_read_a;
      read_b_reg <= in_read_b;
      write_reg  <= in_write;
    end
  end

  assign iq_write = valid_reg & ~{DISPATCH_WIDTH{stall | clear | rst}};
  assign iq_op    = op_reg;
  assign empty    = ~(|valid_reg) | rst;

  // Scoreboard next state. The order of updates gives the precedence:
  // wakeup set < allocation clear < flush. Register 0 is pinned ready.
  // Clears come from the input side, so they are already visible when the
  // allocating op reaches the register.
  always_comb begin
    ready_next = ready_reg;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      if (wakeup_valid[j]) begin
        ready_next[wakeup_reg[j*PREG_W +: PREG_W]] = 1'b1;
      end
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (in_valid[i] && in_write[i] && !stall && !clear) begin
        ready_next[in_dst[i*PREG_W +: PREG_W]] = 1'b0;
      end
    end
    if (flush) begin
      ready_next = '1;
    end
    ready_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg <= '1;
    end else begin
      ready_reg <= ready_next;
    end
  end

  // Operand readiness per slot
  for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_slot
    logic [PREG_W-1:0] src_a;
    logic [PREG_W-1:0] src_b;
    logic              dep_a;
    logic              dep_b;
    logic              byp_a;
    logic              byp_b;

    assign src_a = src_a_reg[gi*PREG_W +: PREG_W];
    assign src_b = src_b_reg[gi*PREG_W +: PREG_W];

    // An older slot in the same group writing our source means the value
    // cannot be ready yet. A "write" to p0 is discarded, so it never blocks.
    always_comb begin
      dep_a = 1'b0;
      dep_b = 1'b0;
      for (int k = 0; k < gi; k++) begin
        if (write_reg[k] && (dst_reg[k*PREG_W +: PREG_W] != '0)) begin
          if (dst_reg[k*PREG_W +: PREG_W] == src_a) dep_a = 1'b1;
          if (dst_reg[k*PREG_W +: PREG_W] == src_b) dep_b = 1'b1;
        end
      end
    end

    // Same-cycle wakeup bypass
    always_comb begin
      byp_a = 1'b0;
      byp_b = 1'b0;
      for (int j = 0; j < DISPATCH_WIDTH; j++) begin
        if (wakeup_valid[j] && (wakeup_reg[j*PREG_W +: PREG_W] == src_a)) byp_a = 1'b1;
        if (wakeup_valid[j] && (wakeup_reg[j*PREG_W +: PREG_W] == src_b)) byp_b = 1'b1;
      end
    end

    assign iq_ready_a[gi] = !read_a_reg[gi] || (!dep_a && (ready_reg[src_a] || byp_a));
    assign iq_ready_b[gi] = !read_b_reg[gi] || (!dep_b && (ready_reg[src_b] || byp_b));
  end

  // Dispatch counter
  always_comb begin
    pop = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      pop = pop + 32'(iq_write[i]);
    end
    count_next = count_reg + pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign dispatched_count = count_reg;

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage
//   Directed bench for dispatch_stage with default parameters. The bench
//   drives inputs 1 time unit after each rising edge and samples outputs 3
//   time units after that edge. Every expected value is a hand-computed
//   constant.
module tb_dispatch_stage;
  localparam int DW = 2;
  localparam int PW = 7;
  localparam int OW = 64;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             clear;
  logic             flush;
  logic [DW-1:0]    in_valid;
  logic [DW*OW-1:0] in_op;
  logic [DW*PW-1:0] in_src_a;
  logic [DW*PW-1:0] in_src_b;
  logic [DW*PW-1:0] in_dst;
  logic [DW-1:0]    in_read_a;
  logic [DW-1:0]    in_read_b;
  logic [DW-1:0]    in_write;
  logic [DW-1:0]    wakeup_valid;
  logic [DW*PW-1:0] wakeup_reg;
  logic [DW-1:0]    iq_write;
  logic [DW*OW-1:0] iq_op;
  logic [DW-1:0]    iq_ready_a;
  logic [DW-1:0]    iq_ready_b;
  logic             empty;
  logic [31:0]      dispatched_count;

  int n_vec = 0;
  int n_err = 0;

  dispatch_stage #(
    .DISPATCH_WIDTH(DW), .PREG_NUM(128), .PREG_W(PW), .OP_W(OW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_src_a(in_src_a),
    .in_src_b(in_src_b), .in_dst(in_dst), .in_read_a(in_read_a),
    .in_read_b(in_read_b), .in_write(in_write),
    .wakeup_valid(wakeup_valid), .wakeup_reg(wakeup_reg),
    .iq_write(iq_write), .iq_op(iq_op), .iq_ready_a(iq_ready_a),
    .iq_ready_b(iq_ready_b), .empty(empty),
    .dispatched_count(dispatched_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %0h expected %0h", n_vec, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid     = '0;
    in_op        = '0;
    in_src_a     = '0;
    in_src_b     = '0;
    in_dst       = '0;
    in_read_a    = '0;
    in_read_b    = '0;
    in_write     = '0;
    wakeup_valid = '0;
    wakeup_reg   = '0;
  endtask

  task automatic set_slot(input int i, input logic [63:0] op,
                          input logic [6:0] sa, input logic ra,
                          input logic [6:0] sb, input logic rb,
                          input logic [6:0] d, input logic w);
    in_valid[i]          = 1'b1;
    in_op[i*OW +: OW]    = op;
    in_src_a[i*PW +: PW] = sa;
    in_read_a[i]         = ra;
    in_src_b[i*PW +: PW] = sb;
    in_read_b[i]         = rb;
    in_dst[i*PW +: PW]   = d;
    in_write[i]          = w;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; clear = 1'b0; flush = 1'b0;
    clr_in();

    // Reset
    tick();
    #2;
    chk("rst_iq_write", 64'(iq_write), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_count", 64'(dispatched_count), 64'h0);
    rst = 1'b0;

    // Basic dispatch: p5 -> p9 producer, then a consumer of p9
    set_slot(0, 64'hA0A0_0000_0000_00A0, 7'd5, 1'b1, 7'd0, 1'b0, 7'd9, 1'b1);
    tick();
    clr_in();
    set_slot(1, 64'hB1B1_0000_0000_00B1, 7'd9, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    #2;
    chk("basic_iq_write0", 64'(iq_write), 64'h1);
    chk("basic_ready_a0", 64'(iq_ready_a[0]), 64'h1);
    chk("basic_op0", iq_op[63:0], 64'hA0A0_0000_0000_00A0);
    chk("basic_not_empty", 64'(empty), 64'h0);
    tick();
    clr_in();
    #2;
    chk("basic_iq_write1", 64'(iq_write), 64'h2);
    chk("basic_ready_a1_p9", 64'(iq_ready_a[1]), 64'h0);
    chk("basic_op1", iq_op[127:64], 64'hB1B1_0000_0000_00B1);
    chk("basic_count1", 64'(dispatched_count), 64'h1);
    tick();
    #2;
    chk("basic_empty", 64'(empty), 64'h1);
    chk("basic_count2", 64'(dispatched_count), 64'h2);

    // Bypass: op reading p9 meets a same-cycle wakeup of p9
    set_slot(0, 64'hC0, 7'd9, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    clr_in();
    set_slot(0, 64'hC1, 7'd9, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    #2;
    chk("byp_no_wakeup", 64'(iq_ready_a[0]), 64'h0);
    wakeup_valid = 2'b01;
    wakeup_reg   = 14'd9;
    #1;
    chk("byp_wakeup", 64'(iq_ready_a[0]), 64'h1);
    tick();
    clr_in();
    #2;
    chk("byp_sb_set", 64'(iq_ready_a[0]), 64'h1);
    tick();

    // Group dependence on p12 plus an unread operand
    set_slot(0, 64'h11, 7'd0, 1'b0, 7'd12, 1'b0, 7'd12, 1'b1);
    set_slot(1, 64'h12, 7'd5, 1'b1, 7'd12, 1'b1, 7'd0, 1'b0);
    tick();
    clr_in();
    #2;
    chk("grp_iq_write", 64'(iq_write), 64'h3);
    chk("grp_ready_b1", 64'(iq_ready_b[1]), 64'h0);
    chk("grp_ready_a1", 64'(iq_ready_a[1]), 64'h1);
    chk("grp_unread_b0", 64'(iq_ready_b[0]), 64'h1);
    tick();
    #2;
    chk("grp_count", 64'(dispatched_count), 64'h6);

    // Stall for 3 cycles with valid ops held
    set_slot(0, 64'hD0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd30, 1'b1);
    set_slot(1, 64'hD1, 7'd30, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    clr_in();
    stall = 1'b1;
    set_slot(0, 64'hE0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd31, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("stall_iq_write", 64'(iq_write), 64'h0);
      chk("stall_op0", iq_op[63:0], 64'hD0);
      chk("stall_op1", iq_op[127:64], 64'hD1);
      chk("stall_count", 64'(dispatched_count), 64'h6);
      tick();
    end
    stall = 1'b0;
    clr_in();
    set_slot(0, 64'hE1, 7'd31, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    #2;
    chk("unstall_iq_write", 64'(iq_write), 64'h3);
    chk("unstall_dep_a1", 64'(iq_ready_a[1]), 64'h0);
    tick();
    clr_in();
    #2;
    chk("stall_no_clear_p31", 64'(iq_ready_a[0]), 64'h1);
    chk("stall_count_after", 64'(dispatched_count), 64'h8);
    tick();

    // Clear suppresses the held op
    set_slot(0, 64'hF0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    clr_in();
    clear = 1'b1;
    #2;
    chk("clear_iq_write", 64'(iq_write), 64'h0);
    tick();
    clear = 1'b0;
    #2;
    chk("clear_empty", 64'(empty), 64'h1);
    chk("clear_count", 64'(dispatched_count), 64'h9);

    // Flush: clear beats same-cycle wakeup, flush sets everything
    set_slot(0, 64'h20, 7'd0, 1'b0, 7'd0, 1'b0, 7'd20, 1'b1);
    wakeup_valid = 2'b01;
    wakeup_reg   = 14'd20;
    tick();
    clr_in();
    set_slot(0, 64'h21, 7'd20, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    clr_in();
    #2;
    chk("flush_clear_wins_p20", 64'(iq_ready_a[0]), 64'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_slot(0, 64'h22, 7'd20, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    set_slot(1, 64'h23, 7'd30, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    clr_in();
    #2;
    chk("flush_ready_p20", 64'(iq_ready_a[0]), 64'h1);
    chk("flush_ready_p30", 64'(iq_ready_a[1]), 64'h1);
    tick();
    set_slot(0, 64'h24, 7'd0, 1'b0, 7'd0, 1'b0, 7'd21, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clr_in();
    set_slot(0, 64'h25, 7'd21, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    clr_in();
    #2;
    chk("flush_beats_alloc_p21", 64'(iq_ready_a[0]), 64'h1);
    tick();
    #2;
    chk("flush_count", 64'(dispatched_count), 64'hF);

    // Physical register 0 stays ready and never creates a dependence
    set_slot(0, 64'h30, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
    set_slot(1, 64'h31, 7'd0, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    clr_in();
    set_slot(0, 64'h32, 7'd0, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0);
    #2;
    chk("p0_same_group", 64'(iq_ready_a[1]), 64'h1);
    tick();
    clr_in();
    #2;
    chk("p0_after_write", 64'(iq_ready_a[0]), 64'h1);
    tick();
    #2;
    chk("p0_count", 64'(dispatched_count), 64'h12);

    // Reset in the middle of a stall
    set_slot(0, 64'h40, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
    set_slot(1, 64'h41, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    stall = 1'b1;
    rst   = 1'b1;
    #2;
    chk("rst_stall_iq_write", 64'(iq_write), 64'h0);
    chk("rst_stall_empty_during", 64'(empty), 64'h1);
    tick();
    rst = 1'b0;
    #2;
    chk("rst_stall_empty_after", 64'(empty), 64'h1);
    chk("rst_stall_count", 64'(dispatched_count), 64'h0);
    stall = 1'b0;
    clr_in();
    tick();

    // Counter wrap: preload the counter then dispatch two ops
    set_slot(0, 64'h50, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
    set_slot(1, 64'h51, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
    tick();
    clr_in();
    dut.count_reg = 32'hFFFF_FFFF;
    #2;
    chk("wrap_iq_write", 64'(iq_write), 64'h3);
    tick();
    #2;
    chk("wrap_count", 64'(dispatched_count), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
